// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter for ALU, branch and LSU writeback
// Optional macro CDB_ARB_PERF_EN adds per-source grant and conflict counters.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [TAG_W-1:0]  alu_wb_tag,
    input  logic [PREG_W-1:0] alu_wb_prd,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              br_wb_valid,
    output logic              br_wb_ready,
    input  logic [TAG_W-1:0]  br_wb_tag,
    input  logic [PREG_W-1:0] br_wb_prd,
    input  logic [DATA_W-1:0] br_wb_data,
    input  logic              lsu_wb_valid,
    output logic              lsu_wb_ready,
    input  logic [TAG_W-1:0]  lsu_wb_tag,
    input  logic [PREG_W-1:0] lsu_wb_prd,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [PREG_W-1:0] cdb_prd,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant_alu,
    output logic [31:0]       perf_grant_br,
    output logic [31:0]       perf_grant_lsu,
    output logic [31:0]       perf_conflict
`endif
);

    logic [2:0]        hv;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_eff;
    logic [TAG_W-1:0]  tag_q  [3];
    logic [PREG_W-1:0] prd_q  [3];
    logic [DATA_W-1:0] data_q [3];

    logic [2:0]        in_valid;
    logic [TAG_W-1:0]  in_tag  [3];
    logic [PREG_W-1:0] in_prd  [3];
    logic [DATA_W-1:0] in_data [3];

    logic [2:0]        gnt;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [2:0]        idx;
    logic [2:0]        ready;
    logic [2:0]        acc;

    assign in_valid   = {lsu_wb_valid, br_wb_valid, alu_wb_valid};
    assign in_tag[0]  = alu_wb_tag;
    assign in_tag[1]  = br_wb_tag;
    assign in_tag[2]  = lsu_wb_tag;
    assign in_prd[0]  = alu_wb_prd;
    assign in_prd[1]  = br_wb_prd;
    assign in_prd[2]  = lsu_wb_prd;
    assign in_data[0] = alu_wb_data;
    assign in_data[1] = br_wb_data;
    assign in_data[2] = lsu_wb_data;

    // An out-of-range pointer value behaves as slot 0.
    assign rr_eff = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        idx     = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, rr_eff} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!gnt_any && hv[idx[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[1:0];
            end
        end
        gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
    end

    // Ready is a function of slot state and grant only, never of valid.
    assign ready = rst ? 3'b000 : (~hv | gnt);
    assign acc   = in_valid & ready;

    assign alu_wb_ready = ready[0];
    assign br_wb_ready  = ready[1];
    assign lsu_wb_ready = ready[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            hv        <= 3'b000;
            rr_ptr    <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_prd   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 2'd0;
        end else if (flush) begin
            hv        <= 3'b000;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= |hv;
            if (gnt_any) begin
                cdb_tag  <= tag_q[gnt_idx];
                cdb_prd  <= prd_q[gnt_idx];
                cdb_data <= data_q[gnt_idx];
                cdb_src  <= gnt_idx;
                rr_ptr   <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i])      hv[i] <= 1'b1;
                else if (gnt[i]) hv[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && !flush && acc[i]) begin
                tag_q[i]  <= in_tag[i];
                prd_q[i]  <= in_prd[i];
                data_q[i] <= in_data[i];
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic conflict;
    assign conflict = (hv[0] & hv[1]) | (hv[0] & hv[2]) | (hv[1] & hv[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_alu <= 32'd0;
            perf_grant_br  <= 32'd0;
            perf_grant_lsu <= 32'd0;
            perf_conflict  <= 32'd0;
        end else begin
            if (cdb_valid && cdb_src == 2'd0) perf_grant_alu <= perf_grant_alu + 32'd1;
            if (cdb_valid && cdb_src == 2'd1) perf_grant_br  <= perf_grant_br + 32'd1;
            if (cdb_valid && cdb_src == 2'd2) perf_grant_lsu <= perf_grant_lsu + 32'd1;
            if (conflict)                     perf_conflict  <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk, rst, flush;
    logic [2:0]  v;
    logic [4:0]  tg [3];
    logic [6:0]  pd [3];
    logic [31:0] dt [3];
    logic [2:0]  rdy;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [6:0]  cdb_prd;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [31:0] p_alu, p_br, p_lsu, p_conf;
`endif

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_wb_valid(v[0]), .alu_wb_ready(rdy[0]), .alu_wb_tag(tg[0]), .alu_wb_prd(pd[0]), .alu_wb_data(dt[0]),
        .br_wb_valid(v[1]),  .br_wb_ready(rdy[1]),  .br_wb_tag(tg[1]),  .br_wb_prd(pd[1]),  .br_wb_data(dt[1]),
        .lsu_wb_valid(v[2]), .lsu_wb_ready(rdy[2]), .lsu_wb_tag(tg[2]), .lsu_wb_prd(pd[2]), .lsu_wb_data(dt[2]),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_prd(cdb_prd), .cdb_data(cdb_data), .cdb_src(cdb_src)
`ifdef CDB_ARB_PERF_EN
        , .perf_grant_alu(p_alu), .perf_grant_br(p_br), .perf_grant_lsu(p_lsu), .perf_conflict(p_conf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        v = 3'b000;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tg[i] = '0; pd[i] = '0; dt[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [2:0] mask, input logic [4:0] base);
        v = mask;
        for (int i = 0; i < 3; i++) begin
            tg[i] = base + 5'(i);
            pd[i] = 7'(40 + i);
            dt[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    // Reference model: pending results per source, scanned round-robin from a pointer.
    logic        m_pend [3];
    logic [4:0]  m_tag  [3];
    logic [6:0]  m_prd  [3];
    logic [31:0] m_data [3];
    int          m_next;
    logic        m_cv;
    logic [4:0]  m_ctag;
    logic [6:0]  m_cprd;
    logic [31:0] m_cdata;
    logic [1:0]  m_csrc;

    function automatic int mdl_pick();
        for (int k = 0; k < 3; k++)
            if (m_pend[(m_next + k) % 3]) return (m_next + k) % 3;
        return -1;
    endfunction

    function automatic logic mdl_ready(input int i);
        return !rst && (!m_pend[i] || mdl_pick() == i);
    endfunction

    task automatic mdl_step();
        int  w;
        logic take [3];
        w = mdl_pick();
        for (int i = 0; i < 3; i++) take[i] = v[i] && mdl_ready(i);
        if (rst) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
            m_next = 0; m_cv = 0; m_ctag = 0; m_cprd = 0; m_cdata = 0; m_csrc = 0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
            m_cv = 0;
        end else begin
            m_cv = (w >= 0);
            if (w >= 0) begin
                m_ctag = m_tag[w]; m_cprd = m_prd[w]; m_cdata = m_data[w]; m_csrc = 2'(w);
                m_next = (w + 1) % 3;
                m_pend[w] = 1'b0;
            end
            for (int i = 0; i < 3; i++) if (take[i]) begin
                m_pend[i] = 1'b1; m_tag[i] = tg[i]; m_prd[i] = pd[i]; m_data[i] = dt[i];
            end
        end
    endtask

    typedef struct {
        logic [2:0] mask;
        int         n;
        logic [1:0] src [3];
    } vec_t;

    vec_t vecs [5];
    int   lsu_acc [32];
    logic [1:0] prev_src;

    initial begin
        rst = 1'b1;
        idle_inputs();
        v = 3'b111;
        @(negedge clk);

        // Reset held with all inputs valid
        for (int c = 0; c < 3; c++) begin
            chk("rst_ready", {61'd0, rdy}, 64'd0);
            cyc();
        end
        chk("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rst_cdb_tag", {59'd0, cdb_tag}, 64'd0);
        chk("rst_cdb_src", {62'd0, cdb_src}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {61'd0, rdy}, 64'h7);
        idle_inputs();

        // Single ALU result
        do_reset();
        v[0] = 1'b1; tg[0] = 5'd3; pd[0] = 7'd10; dt[0] = 32'h0000_1234;
        cyc();
        idle_inputs();
        chk("single_lat0_valid", {63'd0, cdb_valid}, 64'd0);
        cyc();
        chk("single_valid", {63'd0, cdb_valid}, 64'd1);
        chk("single_src", {62'd0, cdb_src}, 64'd0);
        chk("single_tag", {59'd0, cdb_tag}, 64'd3);
        chk("single_prd", {57'd0, cdb_prd}, 64'd10);
        chk("single_data", {32'd0, cdb_data}, 64'h1234);
        cyc();
        chk("single_end_valid", {63'd0, cdb_valid}, 64'd0);

        // Collision table, each entry from reset so the pointer starts at ALU
        vecs[0] = '{3'b111, 3, '{2'd0, 2'd1, 2'd2}};
        vecs[1] = '{3'b101, 2, '{2'd0, 2'd2, 2'd0}};
        vecs[2] = '{3'b110, 2, '{2'd1, 2'd2, 2'd0}};
        vecs[3] = '{3'b010, 1, '{2'd1, 2'd0, 2'd0}};
        vecs[4] = '{3'b100, 1, '{2'd2, 2'd0, 2'd0}};
        for (int t = 0; t < 5; t++) begin
            do_reset();
            offer(vecs[t].mask, 5'd10);
            cyc();
            idle_inputs();
            if (t == 0) chk("tri_ready_first", {61'd0, rdy}, 64'b001);
            for (int k = 0; k < vecs[t].n; k++) begin
                cyc();
                chk("tbl_valid", {63'd0, cdb_valid}, 64'd1);
                chk("tbl_src", {62'd0, cdb_src}, {62'd0, vecs[t].src[k]});
                chk("tbl_tag", {59'd0, cdb_tag}, {59'd0, 5'd10 + 5'(vecs[t].src[k])});
                if (t == 0 && k == 0) chk("tri_ready_br", {61'd0, rdy}, 64'b011);
                if (t == 0 && k == 1) chk("tri_ready_lsu", {61'd0, rdy}, 64'b111);
            end
            cyc();
            chk("tbl_drain", {63'd0, cdb_valid}, 64'd0);
        end

        // Fairness: ALU always valid, LSU joins at cycle 5
        do_reset();
        prev_src = 2'd3;
        begin
            int a_cnt, l_cnt;
            a_cnt = 0; l_cnt = 0;
            for (int c = 0; c < 30; c++) begin
                if (c >= 10) begin
                    chk("fair_valid", {63'd0, cdb_valid}, 64'd1);
                    if (prev_src != 2'd3)
                        chk("fair_alternate", {63'd0, cdb_src != prev_src}, 64'd1);
                    chk("fair_alu_ready", {63'd0, rdy[0]}, {63'd0, cdb_src == 2'd2});
                end
                if (cdb_valid && cdb_src == 2'd2)
                    chk("fair_lsu_wait", {63'd0, (c - lsu_acc[cdb_tag]) <= 4}, 64'd1);
                if (c >= 10) prev_src = cdb_src;
                v[0] = 1'b1; tg[0] = 5'(a_cnt % 16);
                v[2] = (c >= 5); tg[2] = 5'(16 + (l_cnt % 16));
                #1;
                if (rdy[0]) a_cnt++;
                if (v[2] && rdy[2]) begin
                    lsu_acc[tg[2]] = c;
                    l_cnt++;
                end
                cyc();
            end
            idle_inputs();
        end

        // Flush with all slots full; results offered during flush are dropped
        do_reset();
        offer(3'b111, 5'd7);
        cyc();
        flush = 1'b1;
        offer(3'b111, 5'd20);
        cyc();
        idle_inputs();
        chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
        chk("flush_ready", {61'd0, rdy}, 64'h7);
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("flush_quiet", {63'd0, cdb_valid}, 64'd0);
        end

`ifdef CDB_ARB_PERF_EN
        do_reset();
        for (int r = 0; r < 2; r++) begin
            offer(3'b111, 5'd1);
            cyc();
            idle_inputs();
            for (int c = 0; c < 4; c++) cyc();
        end
        chk("perf_alu", {32'd0, p_alu}, 64'd2);
        chk("perf_br", {32'd0, p_br}, 64'd2);
        chk("perf_lsu", {32'd0, p_lsu}, 64'd2);
        chk("perf_conflict", {32'd0, p_conf}, 64'd4);
`endif

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
        m_next = 0; m_cv = 0; m_ctag = 0; m_cprd = 0; m_cdata = 0; m_csrc = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", {63'd0, cdb_valid}, {63'd0, m_cv});
            chk("rnd_tag", {59'd0, cdb_tag}, {59'd0, m_ctag});
            chk("rnd_prd", {57'd0, cdb_prd}, {57'd0, m_cprd});
            chk("rnd_data", {32'd0, cdb_data}, {32'd0, m_cdata});
            chk("rnd_src", {62'd0, cdb_src}, {62'd0, m_csrc});
            rst   = ($urandom % 250) == 0;
            flush = ($urandom % 40) == 0;
            for (int i = 0; i < 3; i++) begin
                v[i]  = ($urandom % 4) != 0;
                tg[i] = 5'($urandom);
                pd[i] = 7'($urandom);
                dt[i] = $urandom;
            end
            #1;
            for (int i = 0; i < 3; i++)
                chk("rnd_ready", {63'd0, rdy[i]}, {63'd0, mdl_ready(i)});
            mdl_step();
            cyc();
        end
        rst = 1'b0;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
